// File: rtl/key_reg_ctrl.sv
// key_reg_ctrl
//   Turns the PS/2 scan-byte stream into clear/load/hold commands for the 8-bit key register.
//   It removes the 0xE0 (extended) and 0xF0 (break) prefixes and loads make codes. It clears
//   the register on the matching break and swallows typematic repeats. It also reports the
//   held-key status.
//
// Ports
//   clk         in   system clock, posedge
//   rst         in   synchronous active-high reset
//   scan_data   in   [7:0] received scan byte
//   scan_valid  in   one-cycle strobe qualifying scan_data
//   tn          out  [1:0] register command (00 clear, 01 load, 10 hold), registered
//   reg_data    out  [7:0] register data_in, registered
//   key_valid   out  register holds a valid make code
//   key_ext     out  held code was 0xE0-prefixed
//   busy        out  controller not in IDLE
//   overrun     out  one-cycle pulse: a scan byte arrived while busy and was dropped
module key_reg_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_data,
  input  logic       scan_valid,
  output logic [1:0] tn,
  output logic [7:0] reg_data,
  output logic       key_valid,
  output logic       key_ext,
  output logic       busy,
  output logic       overrun
);

  localparam logic [1:0] TnClr  = 2'b00;
  localparam logic [1:0] TnLoad = 2'b01;
  localparam logic [1:0] TnHold = 2'b10;

  localparam logic [7:0] ExtPrefix = 8'hE0;
  localparam logic [7:0] BrkPrefix = 8'hF0;

  typedef enum logic [2:0] {StInit, StSettle, StIdle, StLoad, StClr} state_e;

  state_e     state_q;
  logic [1:0] init_cnt_q;
  logic [1:0] tn_q;
  logic [7:0] reg_data_q;
  logic [7:0] held_q;
  logic       key_valid_q;
  logic       key_ext_q;
  logic       brk_pend_q;
  logic       ext_pend_q;
  logic       load_pend_q;  // a LOAD is in flight; key_valid rises when it settles
  logic       busy_q;
  logic       overrun_q;

  // Byte names the key already held, with the same extended-ness.
  logic match;
  assign match = key_valid_q && (scan_data == held_q) && (ext_pend_q == key_ext_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StInit;
      init_cnt_q  <= 2'd0;
      tn_q        <= TnClr;
      reg_data_q  <= 8'h00;
      held_q      <= 8'h00;
      key_valid_q <= 1'b0;
      key_ext_q   <= 1'b0;
      brk_pend_q  <= 1'b0;
      ext_pend_q  <= 1'b0;
      load_pend_q <= 1'b0;
      busy_q      <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= scan_valid && (state_q != StIdle);
      unique case (state_q)
        StInit: begin
          if (init_cnt_q == 2'd1) begin
            state_q <= StSettle;
            tn_q    <= TnHold;
          end else begin
            init_cnt_q <= init_cnt_q + 2'd1;
            tn_q       <= TnClr;
          end
        end
        StSettle: begin
          state_q     <= StIdle;
          tn_q        <= TnHold;
          busy_q      <= 1'b0;
          key_valid_q <= key_valid_q | load_pend_q;
          load_pend_q <= 1'b0;
        end
        StIdle: begin
          if (scan_valid) begin
            if (scan_data == ExtPrefix) begin
              ext_pend_q <= 1'b1;
            end else if (scan_data == BrkPrefix) begin
              brk_pend_q <= 1'b1;
            end else if (brk_pend_q) begin
              brk_pend_q <= 1'b0;
              ext_pend_q <= 1'b0;
              if (match) begin
                state_q     <= StClr;
                tn_q        <= TnClr;
                key_valid_q <= 1'b0;
                busy_q      <= 1'b1;
              end
            end else if (match) begin
              // Typematic repeat: nothing reaches the register.
              ext_pend_q <= 1'b0;
            end else begin
              state_q     <= StLoad;
              tn_q        <= TnLoad;
              reg_data_q  <= scan_data;
              held_q      <= scan_data;
              key_ext_q   <= ext_pend_q;
              ext_pend_q  <= 1'b0;
              load_pend_q <= 1'b1;
              busy_q      <= 1'b1;
            end
          end
        end
        StLoad, StClr: begin
          // Always pass through hold so load and clear never abut.
          state_q <= StSettle;
          tn_q    <= TnHold;
        end
        default: begin
          state_q <= StInit;
          tn_q    <= TnClr;
        end
      endcase
    end
  end

  assign tn        = tn_q;
  assign reg_data  = reg_data_q;
  assign key_valid = key_valid_q;
  assign key_ext   = key_ext_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
